// File: rtl/serial_adder.sv
// Multi-cycle adder/subtractor: CHUNK bits per cycle, LSB chunk first.
// Define SERIAL_ADDER_OVERFLOW_EN to compute signed overflow.
module serial_adder #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             carry_i,
  input  logic             sub_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             carry_o,
  output logic             overflow_o
);

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  if ((WIDTH % CHUNK) != 0 || CHUNK > WIDTH || CHUNK < 1) begin : g_chk
    $error("serial_adder: CHUNK must divide WIDTH");
  end

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic             load;
  logic             step;
  logic             last;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res_q;
  logic             c_q;
  logic [CHUNK:0]   csum;

  assign last = (cnt_q == CW'(N - 1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (valid_i) begin
          load    = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (last) state_d = DONE;
      end
      DONE: begin
        if (ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Operands shift down so the active chunk is always at bit 0.
  assign csum = {1'b0, a_q[CHUNK-1:0]}
              + {1'b0, b_q[CHUNK-1:0]}
              + (CHUNK+1)'(c_q);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      a_q   <= '0;
      b_q   <= '0;
      res_q <= '0;
      c_q   <= 1'b0;
      cnt_q <= '0;
    end else if (load) begin
      a_q   <= a_i;
      b_q   <= sub_i ? ~b_i : b_i;
      c_q   <= sub_i | carry_i;
      cnt_q <= '0;
    end else if (step) begin
      a_q   <= a_q >> CHUNK;
      b_q   <= b_q >> CHUNK;
      res_q <= (res_q >> CHUNK)
             | (WIDTH'(csum[CHUNK-1:0]) << (WIDTH - CHUNK));
      c_q   <= csum[CHUNK];
      cnt_q <= last ? '0 : cnt_q + CW'(1);
    end
  end

`ifdef SERIAL_ADDER_OVERFLOW_EN
  logic ovf_q;
  logic msb_cin;

  // Carry into the top bit, recovered from the top chunk's MSB sum.
  assign msb_cin = a_q[CHUNK-1] ^ b_q[CHUNK-1] ^ csum[CHUNK-1];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)             ovf_q <= 1'b0;
    else if (load)         ovf_q <= 1'b0;
    else if (step && last) ovf_q <= msb_cin ^ csum[CHUNK];
  end

  assign overflow_o = ovf_q;
`else
  assign overflow_o = 1'b0;
`endif

  assign ready_o = (state_q == IDLE) & ~rst_i;
  assign valid_o = (state_q == DONE);
  assign sum_o   = res_q;
  assign carry_o = c_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: CHUNK=8 and CHUNK=32 instances.
// Both share inputs; expected values are hand-computed constants.
module tb_serial_adder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid_i = 1'b0;
  logic        ready_i = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        cin = 1'b0;
  logic        sub = 1'b0;

  logic        ready_o, valid_o, carry_o, ovf_o;
  logic [31:0] sum_o;
  logic        ready1, valid1, carry1, ovf1;
  logic [31:0] sum1;

  int total = 0;
  int bad = 0;
  int lat, lat1, hits;
  logic [31:0] held;

`ifdef SERIAL_ADDER_OVERFLOW_EN
  localparam logic OVF_EXP = 1'b1;
`else
  localparam logic OVF_EXP = 1'b0;
`endif

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(32), .CHUNK(8)) dut (
    .clk_i(clk), .rst_i(rst), .valid_i(valid_i), .ready_o(ready_o),
    .a_i(a), .b_i(b), .carry_i(cin), .sub_i(sub),
    .valid_o(valid_o), .ready_i(ready_i), .sum_o(sum_o),
    .carry_o(carry_o), .overflow_o(ovf_o)
  );

  serial_adder #(.WIDTH(32), .CHUNK(32)) dut1 (
    .clk_i(clk), .rst_i(rst), .valid_i(valid_i), .ready_o(ready1),
    .a_i(a), .b_i(b), .carry_i(cin), .sub_i(sub),
    .valid_o(valid1), .ready_i(ready_i), .sum_o(sum1),
    .carry_o(carry1), .overflow_o(ovf1)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present one op, accept on the next edge, wait for valid_o.
  task automatic op(input logic [31:0] av, input logic [31:0] bv,
                    input logic cv, input logic sv);
    a = av; b = bv; cin = cv; sub = sv;
    chk("ready_before", {31'b0, ready_o}, 32'd1);
    valid_i = 1'b1;
    @(posedge clk); #1;
    valid_i = 1'b0;
    lat = 0;
    lat1 = -1;
    while (!valid_o && lat < 50) begin
      @(posedge clk); #1;
      lat++;
      if (valid1 && lat1 < 0) lat1 = lat;
    end
  endtask

  task automatic drain();
    ready_i = 1'b1;
    @(posedge clk); #1;
    ready_i = 1'b0;
  endtask

  initial begin
    #2;
    chk("rst_ready", {31'b0, ready_o}, 32'd0);
    chk("rst_valid", {31'b0, valid_o}, 32'd0);
    chk("rst_sum", sum_o, 32'd0);
    chk("rst_carry", {31'b0, carry_o}, 32'd0);
    chk("rst_ovf", {31'b0, ovf_o}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_ready", {31'b0, ready_o}, 32'd1);

    op(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0);
    chk("ff_lat", lat, 32'd4);
    chk("ff_sum", sum_o, 32'h0000_0100);
    chk("ff_carry", {31'b0, carry_o}, 32'd0);
    drain();

    op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    chk("ripple_lat", lat, 32'd4);
    chk("ripple_sum", sum_o, 32'h0);
    chk("ripple_carry", {31'b0, carry_o}, 32'd1);
    chk("c32_lat", lat1, 32'd1);
    chk("c32_sum", sum1, 32'h0);
    chk("c32_carry", {31'b0, carry1}, 32'd1);
    drain();

    op(32'd5, 32'd7, 1'b1, 1'b1);
    chk("sub_sum", sum_o, 32'hFFFF_FFFE);
    chk("sub_carry", {31'b0, carry_o}, 32'd0);
    chk("sub_ovf", {31'b0, ovf_o}, 32'd0);
    drain();

    op(32'd10, 32'd3, 1'b0, 1'b1);
    chk("sub2_sum", sum_o, 32'd7);
    chk("sub2_carry", {31'b0, carry_o}, 32'd1);
    drain();

    op(32'd1, 32'd1, 1'b1, 1'b0);
    chk("cin_sum", sum_o, 32'd3);
    drain();

    op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    chk("ovf_sum", sum_o, 32'h8000_0000);
    chk("ovf_flag", {31'b0, ovf_o}, {31'b0, OVF_EXP});
    chk("ovf_carry", {31'b0, carry_o}, 32'd0);
    chk("c32_ovf_flag", {31'b0, ovf1}, {31'b0, OVF_EXP});
    drain();

    // Back-pressure in DONE with a pending new request.
    op(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0);
    chk("bp_sum", sum_o, 32'h2345_6789);
    a = 32'd1; b = 32'd1; cin = 1'b0; sub = 1'b0;
    valid_i = 1'b1;
    hits = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (valid_o === 1'b1 && ready_o === 1'b0 &&
          sum_o === 32'h2345_6789 && carry_o === 1'b0) hits++;
    end
    chk("bp_hold", hits, 32'd5);
    ready_i = 1'b1;
    @(posedge clk); #1;
    ready_i = 1'b0;
    chk("bp_idle_valid", {31'b0, valid_o}, 32'd0);
    chk("bp_idle_ready", {31'b0, ready_o}, 32'd1);
    @(posedge clk); #1;
    valid_i = 1'b0;
    lat = 0;
    while (!valid_o && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("bp_next_lat", lat, 32'd4);
    chk("bp_next_sum", sum_o, 32'd2);
    drain();

    // Reset mid-RUN aborts without a result.
    a = 32'hFFFF_FFFF; b = 32'd1; cin = 1'b0; sub = 1'b0;
    valid_i = 1'b1;
    @(posedge clk); #1;
    valid_i = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("abort_valid", {31'b0, valid_o}, 32'd0);
    chk("abort_sum", sum_o, 32'd0);
    chk("abort_ready", {31'b0, ready_o}, 32'd0);
    #1;
    rst = 1'b0;
    hits = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (valid_o !== 1'b0) hits++;
    end
    chk("abort_no_valid", hits, 32'd0);

    op(32'd3, 32'd4, 1'b0, 1'b0);
    chk("after_lat", lat, 32'd4);
    chk("after_sum", sum_o, 32'd7);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
